// File: rtl/pc_ctrl_pkg.sv
// Shared constants and types for the fetch-stage PC sequencer.
package pc_ctrl_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int STALL_W     = 6;

  localparam int STALL_BIT_PC  = 0;
  localparam int STALL_BIT_IF  = 1;
  localparam int STALL_BIT_ID  = 2;
  localparam int STALL_BIT_EX  = 3;
  localparam int STALL_BIT_MEM = 4;
  localparam int STALL_BIT_WB  = 5;

  // Each encoding freezes every stage up to and including the requester.
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/pc_redirect_buf.sv
// Holds a branch target resolved while fetch could not accept it (stall or memory wait).
module pc_redirect_buf
  import pc_ctrl_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic [ADDR_W-1:0] capture_pc,
  input  logic              consume,
  input  logic              clear,
  output logic              br_pend,
  output logic [ADDR_W-1:0] br_pc
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      br_pend <= 1'b0;
      br_pc   <= '0;
    end else if (clear) begin
      br_pend <= 1'b0;
    end else if (capture) begin
      br_pend <= 1'b1;
      br_pc   <= capture_pc;
    end else if (consume) begin
      br_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch sequencer: owns pc and imem ce, arbitrates flush/stall/ack/branch each cycle.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = INST_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                INC      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_req_id,
  input  logic               stall_req_ex,
  input  logic               branch_flag,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  new_pc,
  input  logic               imem_ack,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               if_valid,
  output logic [STALL_W-1:0] stall,
  output logic               flush_out
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc_n;
  logic              ce_n, if_valid_n, flush_out_n;
  logic              capture, consume, clear;
  logic              br_pend;
  logic [ADDR_W-1:0] br_pc;

  pc_redirect_buf #(.ADDR_W(ADDR_W)) u_redirect (
    .clk        (clk),
    .rst        (rst),
    .capture    (capture),
    .capture_pc (branch_target),
    .consume    (consume),
    .clear      (clear),
    .br_pend    (br_pend),
    .br_pc      (br_pc)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      ce        <= CHIP_DISABLE;
      if_valid  <= 1'b0;
      flush_out <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      ce        <= ce_n;
      if_valid  <= if_valid_n;
      flush_out <= flush_out_n;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    ce_n        = ce;
    if_valid_n  = 1'b0;
    flush_out_n = 1'b0;
    capture     = 1'b0;
    consume     = 1'b0;
    clear       = 1'b0;
    unique case (state)
      IDLE: begin
        state_n = RUN;
        ce_n    = CHIP_ENABLE;
      end
      RUN: begin
        ce_n = CHIP_ENABLE;
        if (flush) begin
          pc_n        = new_pc;
          flush_out_n = 1'b1;
          clear       = 1'b1;
        end else if (stall_req_ex || stall_req_id) begin
          // The ack (if any) is dropped; memory re-acks the same pc later.
          capture = branch_flag;
        end else if (imem_ack) begin
          if_valid_n = 1'b1;
          consume    = 1'b1;
          if (branch_flag)  pc_n = branch_target;
          else if (br_pend) pc_n = br_pc;
          else              pc_n = pc + ADDR_W'(INC);
        end else begin
          capture = branch_flag;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    stall = STALL_NONE;
    if (rst == RST_ENABLE || state == IDLE || flush) stall = STALL_NONE;
    else if (stall_req_ex)                           stall = STALL_EX;
    else if (stall_req_id)                           stall = STALL_ID;
    else if (ce && !imem_ack)                        stall = STALL_IF;
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl with hand-computed expected values.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall_req_id, stall_req_ex, branch_flag, flush, imem_ack;
  logic [31:0] branch_target, new_pc, pc;
  logic        ce, if_valid, flush_out;
  logic [5:0]  stall;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stall_req_id  (stall_req_id),
    .stall_req_ex  (stall_req_ex),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .flush         (flush),
    .new_pc        (new_pc),
    .imem_ack      (imem_ack),
    .pc            (pc),
    .ce            (ce),
    .if_valid      (if_valid),
    .stall         (stall),
    .flush_out     (flush_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one posedge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_req_id = 0; stall_req_ex = 0; branch_flag = 0; flush = 0;
    branch_target = '0; new_pc = '0;
  endtask

  task automatic check_regs(input string tag, input logic [31:0] exp_pc,
                            input logic exp_ce, input logic exp_valid, input logic exp_fl);
    check({tag, ".pc"}, pc, exp_pc);
    check({tag, ".ce"}, {31'd0, ce}, {31'd0, exp_ce});
    check({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, exp_valid});
    check({tag, ".flush_out"}, {31'd0, flush_out}, {31'd0, exp_fl});
  endtask

  initial begin
    idle_inputs();
    rst = 1; imem_ack = 0;
    #1;
    tick(); tick();
    check_regs("reset", 32'h0, 0, 0, 0);
    check("reset.stall", {26'd0, stall}, 32'h0);

    // Release with ack high: IDLE ignores it, first request presents RESET_PC.
    rst = 0; imem_ack = 1;
    #1 check("idle.stall", {26'd0, stall}, 32'h0);
    tick(); check_regs("run0", 32'h0, 1, 0, 0);
    check("run0.stall", {26'd0, stall}, 32'h0);
    tick(); check_regs("run4", 32'h4, 1, 1, 0);
    tick(); check_regs("run8", 32'h8, 1, 1, 0);

    // Memory wait for 3 cycles at pc=8.
    imem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("wait%0d.stall", i), {26'd0, stall}, 32'h03);
      tick(); check_regs($sformatf("wait%0d", i), 32'h8, 1, 0, 0);
    end
    imem_ack = 1;
    #1 check("wait_end.stall", {26'd0, stall}, 32'h0);
    tick(); check_regs("run12", 32'hC, 1, 1, 0);

    // EX stall with branch captured during the stall; ack is present but discarded.
    stall_req_ex = 1; branch_flag = 1; branch_target = 32'h100;
    #1 check("ex0.stall", {26'd0, stall}, 32'h0F);
    tick(); check_regs("ex0", 32'hC, 1, 0, 0);
    branch_flag = 0; branch_target = '0;
    #1 check("ex1.stall", {26'd0, stall}, 32'h0F);
    tick(); check_regs("ex1", 32'hC, 1, 0, 0);
    stall_req_ex = 0;
    tick(); check_regs("br_pend_take", 32'h100, 1, 1, 0);
    tick(); check_regs("br_pend_clr", 32'h104, 1, 1, 0);

    // ID stall alone.
    stall_req_id = 1;
    #1 check("id.stall", {26'd0, stall}, 32'h07);
    tick(); check_regs("id", 32'h104, 1, 0, 0);

    // Flush + branch + ack + stall request: flush wins, stall vector forced to zero.
    flush = 1; new_pc = 32'h20; branch_flag = 1; branch_target = 32'h300;
    #1 check("flush.stall", {26'd0, stall}, 32'h0);
    tick(); check_regs("flush", 32'h20, 1, 0, 1);
    idle_inputs();
    tick(); check_regs("post_flush", 32'h24, 1, 1, 0);

    // Wrap-around at the top of the address space.
    branch_flag = 1; branch_target = 32'hFFFF_FFF8;
    tick(); check_regs("wrap_br", 32'hFFFF_FFF8, 1, 1, 0);
    idle_inputs();
    tick(); check_regs("wrap_fc", 32'hFFFF_FFFC, 1, 1, 0);
    tick(); check_regs("wrap_00", 32'h0, 1, 1, 0);

    // Branch resolved during a memory wait, taken on the following ack.
    imem_ack = 0; branch_flag = 1; branch_target = 32'h80;
    tick(); check_regs("wbr_hold", 32'h0, 1, 0, 0);
    branch_flag = 0; branch_target = '0; imem_ack = 1;
    tick(); check_regs("wbr_take", 32'h80, 1, 1, 0);

    // Reset during a memory wait at 0x40, with a late ack.
    branch_flag = 1; branch_target = 32'h40;
    tick(); check_regs("pre_rst", 32'h40, 1, 1, 0);
    idle_inputs(); imem_ack = 0;
    tick(); check_regs("rst_wait", 32'h40, 1, 0, 0);
    rst = 1; imem_ack = 1;
    #1 check("rst.stall", {26'd0, stall}, 32'h0);
    tick(); check_regs("rst_mid", 32'h0, 0, 0, 0);
    rst = 0;
    tick(); check_regs("rst_rel", 32'h0, 1, 0, 0);
    tick(); check_regs("rst_run", 32'h4, 1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Fetch-stage sequencer that owns the program counter and the instruction-memory chip enable.
- Decides each cycle whether the PC advances by 4, takes a branch, takes an exception/flush redirect, or holds.
- Drives the pipeline stall vector and flush pulse consumed by the IF/ID/EX/MEM/WB stage registers.
- Handles a variable-latency instruction memory through a ce/ack handshake.

Parameters:
ADDR_W, 32, PC and target address width
RESET_PC, 32'h00000000, first fetch address after reset
INC, 4, byte increment per sequential fetch

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
stall_req_id  in  1  decode stage requests a stall (load-use hazard)
stall_req_ex  in  1  execute stage requests a stall (multicycle op)
branch_flag  in  1  branch/jump resolved taken, valid for one cycle
branch_target  in  ADDR_W  target address, qualified by branch_flag
flush  in  1  exception/eret redirect, valid for one cycle
new_pc  in  ADDR_W  redirect address, qualified by flush
imem_ack  in  1  instruction at pc is returned this cycle; meaningful only while ce=1
pc  out  ADDR_W  current fetch address (registered)
ce  out  1  instruction-memory enable (registered)
if_valid  out  1  registered pulse: the instruction fetched last cycle is valid for IF/ID
stall  out  6  combinational; bit0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB
flush_out  out  1  registered one-cycle pulse that clears IF/ID..MEM/WB

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_PC, ce=0, if_valid=0, flush_out=0.
  - br_pend=0, br_pc=0, state=IDLE.
  - Applies mid-handshake; any outstanding ack is ignored.
- States:
  - IDLE: ce=0. Next posedge goes to RUN with ce<=1. pc is unchanged, so the first request is RESET_PC.
  - RUN: ce=1 permanently; IDLE is re-entered only via rst.
- Per-posedge priority in RUN (highest first):
  1. flush=1: pc<=new_pc; flush_out<=1; if_valid<=0; br_pend<=0. A coincident imem_ack is discarded.
  2. stall_req_ex or stall_req_id: pc holds; if_valid<=0. If branch_flag=1, capture br_pc<=branch_target and br_pend<=1.
  3. imem_ack=1: if_valid<=1, then:
     - branch_flag=1: pc<=branch_target; br_pend<=0. A live branch overrides any pending one.
     - else br_pend=1: pc<=br_pc; br_pend<=0.
     - else: pc<=pc+INC.
  4. No ack (memory wait): pc holds; if_valid<=0. If branch_flag=1, capture into br_pc/br_pend.
- flush_out and if_valid deassert on the following cycle unless their condition re-occurs.
- stall (combinational):
  - rst or state=IDLE: 6'b000000.
  - stall_req_ex: 6'b001111.
  - else stall_req_id: 6'b000111.
  - else ce & !imem_ack: 6'b000011.
  - else: 6'b000000.
  - flush forces 6'b000000 regardless of stall requests.
- Arithmetic: pc+INC is modulo 2^ADDR_W, so 32'hFFFFFFFC wraps to 32'h00000000. No alignment check; targets are used verbatim.
- Latency:
  - Redirect (branch or flush) to new pc on the bus: 1 cycle.
  - Ack to incremented pc: 1 cycle.
  - Reset release to first ce=1: 1 cycle.
- Simultaneous events:
  - flush + branch_flag: flush wins; the branch is dropped.
  - Stall + ack: the ack is discarded and the same pc is re-presented, so memory must re-ack.

Decomposition:
- Shared package holds:
  - Stall vector width (6) and bit indices.
  - Stall encodings STALL_NONE, STALL_IF, STALL_ID, STALL_EX.
  - RstEnable/ChipEnable/ChipDisable constants.
  - InstAddrBus width.
  - State encoding IDLE/RUN.
- One natural sub-module: pc_redirect_buf. It holds br_pend/br_pc, with capture, consume and clear inputs.

Test Plan:
- Reset, release, memory acks every cycle -> pc: 0 (ce=0), 0 (ce=1), 4, 8, 12; if_valid first high one cycle after the first ack; stall=0.
- imem_ack low for 3 cycles at pc=8 -> pc holds 8; stall=6'b000011 for those 3 cycles; advances to 12 after the ack.
- stall_req_ex for 2 cycles, with branch_flag to 32'h100 during the stall -> pc holds, stall=6'b001111; on the next ack pc=32'h100, br_pend cleared.
- flush with new_pc=32'h20 coincident with branch_flag and imem_ack -> pc=32'h20, flush_out one-cycle pulse, if_valid=0, branch dropped.
- Start at pc=32'hFFFFFFF8 (branch there), two acks -> pc=32'hFFFFFFFC, then 32'h00000000.
- rst asserted while waiting for ack at pc=32'h40 -> next cycle pc=0, ce=0, stall=0, if_valid=0; a late ack is ignored.
